// File: rtl/tile_sprite_addr_gen.sv
// tile_sprite_addr_gen
//   Maps each VGA raster position to an atlas ROM address. The picture is a
//   tiled background with N_SPR independently sized sprites on top of it
//   (sprite 0 has the highest priority). Tile map and sprite state are copied
//   into shadow registers on frame_start so that a frame never tears. The
//   result is registered twice, so the address lines up with a block-ROM read.
//
// Ports
//   clk          pixel clock
//   rst          synchronous reset, active-low
//   frame_start  one-cycle pulse at raster (0,0); loads the shadow registers
//   valid        active-video flag
//   h_cnt/v_cnt  raster column / row
//   tile_map     background atlas indices, entry c + COLS*r at [TYPE_W*i +: TYPE_W]
//   spr_en/x/y/w/h/tile  per-sprite enable, position, size and atlas index
//   pixel_addr   atlas ROM address
//   pixel_valid  pixel_addr belongs to an active pixel
//   pixel_layer  0 = background, i+1 = sprite i
module tile_sprite_addr_gen #(
  parameter int COLS       = 20,
  parameter int ROWS       = 24,
  parameter int TILE_W     = 32,
  parameter int TILE_H     = 20,
  parameter int TYPE_W     = 3,
  parameter int ATLAS_COLS = 3,
  parameter int N_SPR      = 2,
  parameter int ADDR_W     = 17,
  localparam int LAYER_W   = $clog2(N_SPR + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        frame_start,
  input  logic                        valid,
  input  logic [9:0]                  h_cnt,
  input  logic [9:0]                  v_cnt,
  input  logic [COLS*ROWS*TYPE_W-1:0] tile_map,
  input  logic [N_SPR-1:0]            spr_en,
  input  logic [10*N_SPR-1:0]         spr_x,
  input  logic [10*N_SPR-1:0]         spr_y,
  input  logic [6*N_SPR-1:0]          spr_w,
  input  logic [5*N_SPR-1:0]          spr_h,
  input  logic [TYPE_W*N_SPR-1:0]     spr_tile,
  output logic [ADDR_W-1:0]           pixel_addr,
  output logic                        pixel_valid,
  output logic [LAYER_W-1:0]          pixel_layer
);

  localparam int MAP_W  = COLS * ROWS * TYPE_W;
  localparam int MIDX_W = (MAP_W > 1) ? $clog2(MAP_W) : 1;
  localparam int OX_W   = (TILE_W > 1) ? $clog2(TILE_W) : 1;
  localparam int OY_W   = (TILE_H > 1) ? $clog2(TILE_H) : 1;

  function automatic logic [ADDR_W-1:0] atlas_addr(
    input logic [TYPE_W-1:0] k,
    input logic [OX_W-1:0]   ox,
    input logic [OY_W-1:0]   oy
  );
    logic [31:0] a;
    a = 32'(ATLAS_COLS * TILE_W) * ((32'(k) / 32'(ATLAS_COLS)) * 32'(TILE_H) + 32'(oy))
      + (32'(k) % 32'(ATLAS_COLS)) * 32'(TILE_W) + 32'(ox);
    return a[ADDR_W-1:0];
  endfunction

  // Shadow copies of the frame state
  logic [MAP_W-1:0]           map_sh;
  logic [N_SPR-1:0]           en_sh;
  logic [10*N_SPR-1:0]        x_sh, y_sh;
  logic [6*N_SPR-1:0]         w_sh;
  logic [5*N_SPR-1:0]         h_sh;
  logic [TYPE_W*N_SPR-1:0]    tile_sh;

  always_ff @(posedge clk) begin
    if (!rst) begin
      map_sh  <= '0;
      en_sh   <= '0;
      x_sh    <= '0;
      y_sh    <= '0;
      w_sh    <= '0;
      h_sh    <= '0;
      tile_sh <= '0;
    end else if (frame_start) begin
      map_sh  <= tile_map;
      en_sh   <= spr_en;
      x_sh    <= spr_x;
      y_sh    <= spr_y;
      w_sh    <= spr_w;
      h_sh    <= spr_h;
      tile_sh <= spr_tile;
    end
  end

  // A pixel arriving together with frame_start already sees the new state,
  // so the lookups bypass the shadow registers in that cycle.
  logic [MAP_W-1:0]        map_eff;
  logic [N_SPR-1:0]        en_eff;
  logic [10*N_SPR-1:0]     x_eff, y_eff;
  logic [6*N_SPR-1:0]      w_eff;
  logic [5*N_SPR-1:0]      h_eff;
  logic [TYPE_W*N_SPR-1:0] tile_eff;

  assign map_eff  = frame_start ? tile_map : map_sh;
  assign en_eff   = frame_start ? spr_en   : en_sh;
  assign x_eff    = frame_start ? spr_x    : x_sh;
  assign y_eff    = frame_start ? spr_y    : y_sh;
  assign w_eff    = frame_start ? spr_w    : w_sh;
  assign h_eff    = frame_start ? spr_h    : h_sh;
  assign tile_eff = frame_start ? spr_tile : tile_sh;

  // Stage 1: background cell lookup and per-sprite hit test
  int                  col_c, row_c;
  logic [MIDX_W-1:0]   midx_c;
  logic [TYPE_W-1:0]   bgk_c;
  logic [OX_W-1:0]     tx_c;
  logic [OY_W-1:0]     ty_c;

  always_comb begin
    col_c  = int'(32'(h_cnt) / 32'(TILE_W));
    row_c  = int'(32'(v_cnt) / 32'(TILE_H));
    tx_c   = OX_W'(32'(h_cnt) % 32'(TILE_W));
    ty_c   = OY_W'(32'(v_cnt) % 32'(TILE_H));
    midx_c = '0;
    bgk_c  = '0;
    // Off-map raster positions fall back to atlas cell 0.
    if (col_c < COLS && row_c < ROWS) begin
      midx_c = MIDX_W'(TYPE_W * (col_c + COLS * row_c));
      bgk_c  = map_eff[midx_c +: TYPE_W];
    end
  end

  logic [N_SPR-1:0]        hit_c;
  logic [N_SPR*OX_W-1:0]   sox_c;
  logic [N_SPR*OY_W-1:0]   soy_c;

  for (genvar g = 0; g < N_SPR; g++) begin : g_spr
    // Edge sums are 11 bits wide so a sprite near column 1023 cannot wrap.
    assign hit_c[g] = en_eff[g]
                   && (h_cnt >= x_eff[10*g +: 10])
                   && ({1'b0, h_cnt} < ({1'b0, x_eff[10*g +: 10]} + {5'b0, w_eff[6*g +: 6]}))
                   && (v_cnt >= y_eff[10*g +: 10])
                   && ({1'b0, v_cnt} < ({1'b0, y_eff[10*g +: 10]} + {6'b0, h_eff[5*g +: 5]}));
    // Offsets are relative to the sprite origin, not to the screen tile grid.
    assign sox_c[g*OX_W +: OX_W] = OX_W'(h_cnt - x_eff[10*g +: 10]);
    assign soy_c[g*OY_W +: OY_W] = OY_W'(v_cnt - y_eff[10*g +: 10]);
  end

  logic                    vld_p1;
  logic [TYPE_W-1:0]       bgk_p1;
  logic [OX_W-1:0]         tx_p1;
  logic [OY_W-1:0]         ty_p1;
  logic [N_SPR-1:0]        hit_p1;
  logic [N_SPR*OX_W-1:0]   sox_p1;
  logic [N_SPR*OY_W-1:0]   soy_p1;
  logic [TYPE_W*N_SPR-1:0] stile_p1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p1   <= 1'b0;
      bgk_p1   <= '0;
      tx_p1    <= '0;
      ty_p1    <= '0;
      hit_p1   <= '0;
      sox_p1   <= '0;
      soy_p1   <= '0;
      stile_p1 <= '0;
    end else begin
      vld_p1   <= valid;
      bgk_p1   <= bgk_c;
      tx_p1    <= tx_c;
      ty_p1    <= ty_c;
      hit_p1   <= hit_c;
      sox_p1   <= sox_c;
      soy_p1   <= soy_c;
      stile_p1 <= tile_eff;
    end
  end

  // Stage 2: priority select and atlas address
  // Chain runs from the background up through sprite 0, so the lowest-index
  // hit overrides everything behind it.
  logic [TYPE_W-1:0]  k_ch  [N_SPR+1];
  logic [OX_W-1:0]    ox_ch [N_SPR+1];
  logic [OY_W-1:0]    oy_ch [N_SPR+1];
  logic [LAYER_W-1:0] ly_ch [N_SPR+1];

  assign k_ch[N_SPR]  = bgk_p1;
  assign ox_ch[N_SPR] = tx_p1;
  assign oy_ch[N_SPR] = ty_p1;
  assign ly_ch[N_SPR] = '0;

  for (genvar g = 0; g < N_SPR; g++) begin : g_pri
    assign k_ch[g]  = hit_p1[g] ? stile_p1[TYPE_W*g +: TYPE_W] : k_ch[g+1];
    assign ox_ch[g] = hit_p1[g] ? sox_p1[OX_W*g +: OX_W]       : ox_ch[g+1];
    assign oy_ch[g] = hit_p1[g] ? soy_p1[OY_W*g +: OY_W]       : oy_ch[g+1];
    assign ly_ch[g] = hit_p1[g] ? LAYER_W'(g + 1)              : ly_ch[g+1];
  end

  logic [ADDR_W-1:0] addr_c;
  assign addr_c = atlas_addr(k_ch[0], ox_ch[0], oy_ch[0]);

  always_ff @(posedge clk) begin
    if (!rst) begin
      pixel_addr  <= '0;
      pixel_valid <= 1'b0;
      pixel_layer <= '0;
    end else if (vld_p1) begin
      pixel_addr  <= addr_c;
      pixel_valid <= 1'b1;
      pixel_layer <= ly_ch[0];
    end else begin
      pixel_addr  <= '0;
      pixel_valid <= 1'b0;
      pixel_layer <= '0;
    end
  end

endmodule

// File: doc/tile_sprite_addr_gen.md
Name: tile_sprite_addr_gen

Overview:
Parametrised successor to the single-ball/single-board pixel address generator. Maps each VGA raster position to an atlas ROM address, composing a tiled background with N_SPR independently sized sprites under fixed priority. Tile map and sprite state are shadowed at frame start to prevent tearing. Output is pipelined (2 cycles) so the registered address lines up with the block-ROM read. Sits between vga_controller and the atlas block ROM.

Parameters:
COLS, 20, background tiles per row
ROWS, 24, background tile rows
TILE_W, 32, tile/sprite cell width in pixels
TILE_H, 20, tile/sprite cell height in pixels
TYPE_W, 3, bits per tile/sprite atlas index
ATLAS_COLS, 3, atlas cells per atlas row; atlas pixel row stride = ATLAS_COLS*TILE_W
N_SPR, 2, sprite count; sprite 0 has highest priority
ADDR_W, 17, pixel_addr width
LAYER_W = $clog2(N_SPR+1) is a localparam, not overridable.

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous reset, active-low
frame_start  in  1  one-cycle pulse at raster (0,0)
valid  in  1  active-video flag from vga_controller
h_cnt  in  10  raster column
v_cnt  in  10  raster row
tile_map  in  COLS*ROWS*TYPE_W  tile atlas index; entry i = c + COLS*r at [TYPE_W*i +: TYPE_W]
spr_en  in  N_SPR  per-sprite enable
spr_x  in  10*N_SPR  sprite left edge
spr_y  in  10*N_SPR  sprite top edge
spr_w  in  6*N_SPR  sprite width in pixels, 1..TILE_W
spr_h  in  5*N_SPR  sprite height in pixels, 1..TILE_H
spr_tile  in  TYPE_W*N_SPR  sprite atlas index
pixel_addr  out  ADDR_W  atlas ROM address
pixel_valid  out  1  pixel_addr corresponds to an active pixel
pixel_layer  out  LAYER_W  0 = background, i+1 = sprite i

Behaviour:
- Reset (rst==0 at a clk edge): pixel_addr=0, pixel_valid=0, pixel_layer=0; all pipeline registers, shadow tile map and shadow sprite registers cleared to 0. Reset mid-frame: outputs 0 on the next edge; stream resumes 2 cycles after release.
- Shadowing: on frame_start==1, capture tile_map, spr_en, spr_x, spr_y, spr_w, spr_h, spr_tile into shadow registers (values present in that same cycle). Shadow registers hold otherwise; all lookups use shadow copies only.
- Stage 1 (edge N): register valid, h, v; compute tile col = h/TILE_W, row = v/TILE_H, tx = h%TILE_W, ty = v%TILE_H; per sprite compute hit and offsets.
- Sprite hit i: en_i && h >= x_i && h < x_i+w_i && v >= y_i && v < y_i+h_i. Sums are 11-bit (no wrap). Offsets: ox = h-x_i, oy = v-y_i (sprite-relative, not screen-aligned).
- Stage 2 (edge N+1): pick lowest-index hit sprite; else background. Register outputs. Total latency: inputs at edge N appear on outputs after edge N+2.
- Atlas address for index k with in-cell offset (ox,oy): (ATLAS_COLS*TILE_W)*((k/ATLAS_COLS)*TILE_H + oy) + (k%ATLAS_COLS)*TILE_W + ox, truncated to ADDR_W.
- Background uses k = shadow tile_map[col,row], (ox,oy) = (tx,ty). If row >= ROWS or col >= COLS, use k=0.
- valid==0: pixel_addr=0, pixel_valid=0, pixel_layer=0 (after pipeline delay); sprite hits are ignored.
- frame_start coincident with an active pixel: that pixel already uses the newly captured values.

Test Plan:
1. Hold rst=0 3 cycles -> all outputs 0. Release; valid=1, h=40, v=25 -> 2 cycles later addr=488 (type 0), layer 0, pixel_valid=1.
2. tile_map entry 21=2, frame_start, then (40,25) -> addr=552; entry 21=4 with a new frame_start -> addr=2440.
3. Change entry 21 from 2 to 4 with no frame_start -> addr stays 552 until the next frame_start pulse, then becomes 2440.
4. Sprite setup: spr0=(100,100,w16,h10,tile2), spr1=(105,102,w32,h10,tile4), both enabled. Pixel (110,104) -> addr=458, layer 1. Clear spr_en[0] and pulse frame_start -> addr=2149, layer 2.
5. Edges: spr0 x=630, w=16, y=100; (639,100) -> hit, ox=9, addr=73. With x=100, w=16: h=115 -> hit; h=116 -> background. Apply valid=0 -> addr 0, pixel_valid 0, layer 0.
6. Stream h=0..639 on one line, then assert rst=0 mid-line -> outputs 0 at the next edge. After release, the first valid output appears exactly 2 cycles later.
